audio_dc_decimator: RTL

Conditions the mainboard's raw mixed audio before it reaches the I2S/HDMI audio encoder. It box-filter decimates the per-strobe audio stream (e.g. clk_3mhz_en rate), removes DC with a single-pole high-pass filter, applies a shift-attenuation volume and mute, and saturates to the PCM width. Fully pipelined in the system clock domain; the output feeds the encoder's pcm_in register.

---
 rtl/audio_dc_decimator.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/audio_dc_decimator.sv
// ---------------------------------------------------------------------------
// audio_dc_decimator
//
// Conditions the raw mixed audio stream before the I2S/HDMI encoder:
//   stage 0  box-filter decimation: 2^DECIM_LOG2 strobed samples are summed,
//            and the floor of their average is taken when a block completes
//   stage 1  single-pole DC blocker, y[n] = x[n] - x[n-1] + a*y[n-1],
//            a = 1 - 2^-DCB_SHIFT, kept in fixed point (y_fix = y * 2^DCB_SHIFT)
//   stage 2  DC-blocker output register
//   stage 3  volume shift, mute, saturate to AUDIO_BITS, sticky clip flag
//
// Optional build macro: AUDIO_SOFT_MUTE_EN
//   undefined -> mute forces the output sample to zero (hard mute)
//   defined   -> a 5-bit gain (0..16, /16) ramps one step per output sample
//                toward 0 while muted and toward 16 otherwise
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   sample_en  single-cycle input sample strobe
//   audio_in   signed input sample, qualified by sample_en
//   volume     attenuation as an arithmetic right shift, 0..7
//   mute       output silence request (filter state keeps running)
//   clip_clr   clears the sticky clip flag; a simultaneous set wins
//   audio_out  signed output sample, held between updates
//   out_valid  one-cycle pulse when audio_out updates
//   clip       sticky saturation flag
//
// DECIM_LOG2 is legal over 1..10. out_valid rises 3 edges after the edge that
// samples the final strobe of a block; the pipeline never stalls.
// ---------------------------------------------------------------------------
module audio_dc_decimator #(
  parameter int AUDIO_BITS = 16,
  parameter int DECIM_LOG2 = 6,
  parameter int DCB_SHIFT  = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_en,
  input  logic signed [AUDIO_BITS-1:0] audio_in,
  input  logic [2:0]                   volume,
  input  logic                         mute,
  input  logic                         clip_clr,
  output logic signed [AUDIO_BITS-1:0] audio_out,
  output logic                         out_valid,
  output logic                         clip
);

  localparam int ACC_W  = AUDIO_BITS + DECIM_LOG2;
  localparam int YF_W   = AUDIO_BITS + DCB_SHIFT + 2;
  localparam int Y_W    = YF_W - DCB_SHIFT;
  localparam int STAGES = 3;

`ifdef AUDIO_SOFT_MUTE_EN
  // room for the 6-bit signed gain product before the /16
  localparam int Z_W = Y_W + 6;
`else
  localparam int Z_W = Y_W;
`endif

  // vld_pipe[0]: x valid, [1]: y_fix updated, [2]: y_r valid, [3]: out_valid
  logic [STAGES:0] vld_pipe;

  // -------------------------------------------------------------------------
  // stage 0: decimation accumulator
  // -------------------------------------------------------------------------
  logic [DECIM_LOG2-1:0]        cnt;
  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      in_ext;
  logic signed [ACC_W-1:0]      acc_sum;
  logic                         cnt_last;
  logic signed [AUDIO_BITS-1:0] x;

  assign in_ext   = {{DECIM_LOG2{audio_in[AUDIO_BITS-1]}}, audio_in};
  assign acc_sum  = acc + in_ext;
  assign cnt_last = &cnt;

  // The closing strobe's sample is folded in through acc_sum and the
  // accumulator restarts from zero on the same edge, so every strobe lands in
  // exactly one block. Dropping the low bits is an arithmetic (floor) shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      x   <= '0;
    end else if (sample_en) begin
      cnt <= cnt + DECIM_LOG2'(1);
      if (cnt_last) begin
        acc <= '0;
        x   <= acc_sum[ACC_W-1:DECIM_LOG2];
      end else begin
        acc <= acc_sum;
      end
    end
  end

  // -------------------------------------------------------------------------
  // valid shift register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:0], sample_en & cnt_last};
  end

  assign out_valid = vld_pipe[STAGES];

  // -------------------------------------------------------------------------
  // stage 1: DC blocker
  // -------------------------------------------------------------------------
  logic signed [AUDIO_BITS-1:0] x_prev;
  logic signed [AUDIO_BITS:0]   dx;
  logic signed [YF_W-1:0]       dx_sh;
  logic signed [YF_W-1:0]       y_fix;
  logic signed [YF_W-1:0]       yf_leak;
  logic signed [YF_W-1:0]       y_fix_nxt;

  assign dx        = {x[AUDIO_BITS-1], x} - {x_prev[AUDIO_BITS-1], x_prev};
  assign dx_sh     = {{(YF_W-AUDIO_BITS-1){dx[AUDIO_BITS]}}, dx} << DCB_SHIFT;
  // a*y = y - y*2^-DCB_SHIFT, so the pole needs no multiplier
  assign yf_leak   = y_fix >>> DCB_SHIFT;
  assign y_fix_nxt = dx_sh + y_fix - yf_leak;

  always_ff @(posedge clk) begin
    if (reset) begin
      x_prev <= '0;
      y_fix  <= '0;
    end else if (vld_pipe[0]) begin
      x_prev <= x;
      y_fix  <= y_fix_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // stage 2: integer part of the DC-blocker output
  // -------------------------------------------------------------------------
  logic signed [Y_W-1:0] y_r;

  always_ff @(posedge clk) begin
    if (reset)            y_r <= '0;
    else if (vld_pipe[1]) y_r <= y_fix[YF_W-1:DCB_SHIFT];
  end

  // -------------------------------------------------------------------------
  // stage 3: volume, mute, saturation
  // -------------------------------------------------------------------------
  logic signed [Y_W-1:0] z_sh;
  logic signed [Z_W-1:0] z;

  assign z_sh = y_r >>> volume;

`ifdef AUDIO_SOFT_MUTE_EN
  logic [4:0]            gain;
  logic signed [5:0]     gain_s;
  logic signed [Z_W-1:0] prod;

  assign gain_s = {1'b0, gain};
  assign prod   = Z_W'(z_sh) * Z_W'(gain_s);
  assign z      = prod >>> 4;

  // gain is used at its current value, then steps once per output sample
  always_ff @(posedge clk) begin
    if (reset) begin
      gain <= 5'd16;
    end else if (vld_pipe[STAGES-1]) begin
      if (mute) begin
        if (gain != 5'd0) gain <= gain - 5'd1;
      end else begin
        if (gain != 5'd16) gain <= gain + 5'd1;
      end
    end
  end
`else
  assign z = mute ? '0 : Z_W'(z_sh);
`endif

  // z fits in AUDIO_BITS when every bit from the output sign bit up agrees
  logic [Z_W-AUDIO_BITS:0]      z_top;
  logic                         sat;
  logic signed [AUDIO_BITS-1:0] z_sat;

  assign z_top = z[Z_W-1:AUDIO_BITS-1];
  assign sat   = ~((&z_top) | (~|z_top));
  assign z_sat = !sat        ? z[AUDIO_BITS-1:0] :
                 z[Z_W-1]    ? {1'b1, {(AUDIO_BITS-1){1'b0}}} :
                               {1'b0, {(AUDIO_BITS-1){1'b1}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      audio_out <= '0;
      clip      <= 1'b0;
    end else begin
      if (vld_pipe[STAGES-1]) audio_out <= z_sat;
      if (vld_pipe[STAGES-1] && sat) clip <= 1'b1;
      else if (clip_clr)             clip <= 1'b0;
    end
  end

endmodule
